// File: rtl/uart_pkg.sv
// Shared UART framing constants, parser state encoding and frame payload types.
// Imported by the RX frame parser and reused by the TX-side response framer.
package uart_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned TIMER_W = 24;

    localparam logic [BYTE_W-1:0] SOF_BYTE = 8'hA5;
    localparam logic [BYTE_W-1:0] CMD_WR   = 8'h01;
    localparam logic [BYTE_W-1:0] CMD_RD   = 8'h02;

    typedef enum logic [2:0] {
        IDLE,
        GET_CMD,
        GET_ADDR,
        GET_DATA,
        GET_CHK
    } parseState_t;

    typedef struct packed {
        logic [BYTE_W-1:0] addr;
        logic [BYTE_W-1:0] data;
    } regFrame_t;

    function automatic logic [BYTE_W-1:0] frameChk(input logic [BYTE_W-1:0] cmd,
                                                   input logic [BYTE_W-1:0] addr,
                                                   input logic [BYTE_W-1:0] data);
        return cmd ^ addr ^ data;
    endfunction

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte timer: clearable up-counter with a registered terminal-count flag.
// oTc is high during the cycle in which the count equals TIMEOUT_CYC-1.
module uart_byte_timer
    import uart_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iClr,
    input  logic iEn,
    output logic oTc
);

    localparam logic [TIMER_W-1:0] TC_VAL = TIMER_W'(TIMEOUT_CYC - 1);

    logic [TIMER_W-1:0] cnt;
    logic [TIMER_W-1:0] cntNxt;

    always_comb begin
        cntNxt = cnt;
        if (iClr) begin
            cntNxt = '0;
        end else if (iEn) begin
            cntNxt = cnt + TIMER_W'(1);
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            cnt <= '0;
            oTc <= 1'b0;
        end else begin
            cnt <= cntNxt;
            oTc <= (cntNxt == TC_VAL);
        end
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Parses SOF/CMD/ADDR/DATA/CHK frames from a UART byte stream into register
// read/write strobes, with inter-byte timeout and a saturating error counter.
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [BYTE_W-1:0] iData,
    input  logic              iValid,
    output logic              oWrEn,
    output logic              oRdEn,
    output logic [BYTE_W-1:0] oAddr,
    output logic [BYTE_W-1:0] oWrData,
    output logic              oFrameErr,
    output logic [BYTE_W-1:0] oErrCnt,
    output logic              oBusy
);

    parseState_t       state, stateNxt;
    logic [BYTE_W-1:0] cmdQ, cmdNxt;
    regFrame_t         holdQ, holdNxt;
    logic [BYTE_W-1:0] addrNxt, wrDataNxt, errCntNxt;
    logic              wrEnNxt, rdEnNxt, errNxt;
    logic              tmrTc;
    logic              timeout;

    // A byte on the terminal cycle takes priority over the timeout.
    assign timeout = tmrTc && (state != IDLE);

    uart_byte_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) uTimer (
        .iClk(iClk),
        .iRst(iRst),
        .iClr(iValid || (state == IDLE) || timeout),
        .iEn (state != IDLE),
        .oTc (tmrTc)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state     <= IDLE;
            cmdQ      <= '0;
            holdQ     <= '0;
            oAddr     <= '0;
            oWrData   <= '0;
            oWrEn     <= 1'b0;
            oRdEn     <= 1'b0;
            oFrameErr <= 1'b0;
            oErrCnt   <= '0;
            oBusy     <= 1'b0;
        end else begin
            state     <= stateNxt;
            cmdQ      <= cmdNxt;
            holdQ     <= holdNxt;
            oAddr     <= addrNxt;
            oWrData   <= wrDataNxt;
            oWrEn     <= wrEnNxt;
            oRdEn     <= rdEnNxt;
            oFrameErr <= errNxt;
            oErrCnt   <= errCntNxt;
            oBusy     <= (stateNxt != IDLE);
        end
    end

    always_comb begin
        stateNxt  = state;
        cmdNxt    = cmdQ;
        holdNxt   = holdQ;
        addrNxt   = oAddr;
        wrDataNxt = oWrData;
        wrEnNxt   = 1'b0;
        rdEnNxt   = 1'b0;
        errNxt    = 1'b0;

        if (iValid) begin
            case (state)
                IDLE: begin
                    if (iData == SOF_BYTE) begin
                        stateNxt = GET_CMD;
                    end
                end
                GET_CMD: begin
                    if ((iData == CMD_WR) || (iData == CMD_RD)) begin
                        cmdNxt   = iData;
                        stateNxt = GET_ADDR;
                    end else begin
                        errNxt   = 1'b1;
                        stateNxt = IDLE;
                    end
                end
                GET_ADDR: begin
                    holdNxt.addr = iData;
                    stateNxt     = GET_DATA;
                end
                GET_DATA: begin
                    holdNxt.data = iData;
                    stateNxt     = GET_CHK;
                end
                GET_CHK: begin
                    if (iData == frameChk(cmdQ, holdQ.addr, holdQ.data)) begin
                        addrNxt   = holdQ.addr;
                        wrDataNxt = holdQ.data;
                        wrEnNxt   = (cmdQ == CMD_WR);
                        rdEnNxt   = (cmdQ == CMD_RD);
                    end else begin
                        errNxt = 1'b1;
                    end
                    stateNxt = IDLE;
                end
                default: stateNxt = IDLE;
            endcase
        end else if (timeout) begin
            errNxt   = 1'b1;
            stateNxt = IDLE;
        end

        errCntNxt = (errNxt && (oErrCnt != 8'hFF)) ? oErrCnt + 8'd1 : oErrCnt;
    end

endmodule

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 100000, inter-byte timeout in iClk cycles, legal range 2..2^24-1.
REQ-002 Port: iClk  input  1  system clock, all logic on rising edge.
REQ-003 Port: iRst  input  1  reset, asynchronous, active-high.
REQ-004 Port: iData  input  8  received byte from the UART receiver, sampled only when iValid=1.
REQ-005 Port: iValid  input  1  one-cycle byte strobe from the UART receiver.
REQ-006 Port: oWrEn  output  1  one-cycle register-write strobe.
REQ-007 Port: oRdEn  output  1  one-cycle register-read strobe.
REQ-008 Port: oAddr  output  8  register address of the last good frame.
REQ-009 Port: oWrData  output  8  write data of the last good frame.
REQ-010 Port: oFrameErr  output  1  one-cycle frame-error strobe.
REQ-011 Port: oErrCnt  output  8  saturating frame-error count.
REQ-012 Port: oBusy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 Frame format SHALL be 5 bytes in order: SOF=0xA5, CMD, ADDR, DATA, CHK, with CHK = CMD ^ ADDR ^ DATA.
REQ-014 Legal CMD values SHALL be 0x01 (write) and 0x02 (read); for reads DATA is don't-care but SHALL still be included in CHK.
REQ-015 FSM states SHALL be IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CHK; each transition happens only on a cycle with iValid=1, except timeout.
REQ-016 IDLE: byte 0xA5 -> GET_CMD; any other byte is discarded silently, with no error and no count change.
REQ-017 GET_CMD: legal CMD -> capture it and go to GET_ADDR; illegal CMD -> oFrameErr pulse and return to IDLE.
REQ-018 GET_ADDR and GET_DATA SHALL capture the byte into internal holding registers, not into oAddr/oWrData.
REQ-019 GET_CHK, checksum match: on the next cycle, oAddr/oWrData update from the holding registers and oWrEn (CMD 0x01) or oRdEn (CMD 0x02) pulses for exactly 1 cycle; FSM returns to IDLE.
REQ-020 GET_CHK, checksum mismatch: oFrameErr pulses on the next cycle, oAddr/oWrData stay unchanged, FSM returns to IDLE.
REQ-021 Latency from the CHK-byte iValid to oWrEn/oRdEn/oFrameErr SHALL be exactly 1 cycle.
REQ-022 oAddr/oWrData SHALL hold their value until the next good frame; a good read frame updates oAddr, and oWrData takes the received DATA byte.
REQ-023 Inter-byte timer: resets to 0 on every iValid; counts while the FSM is not IDLE; held at 0 in IDLE.
REQ-024 Timeout: when the timer reaches TIMEOUT_CYC-1 with no iValid that cycle, oFrameErr pulses next cycle and the FSM returns to IDLE.
REQ-025 Simultaneous iValid and timer terminal count: the byte wins and no timeout occurs.
REQ-026 A 0xA5 received in any non-IDLE state SHALL be treated as ordinary data; there is no resynchronisation mid-frame.
REQ-027 oErrCnt SHALL increment by 1 on each oFrameErr pulse and saturate at 0xFF.
REQ-028 oWrEn, oRdEn and oFrameErr SHALL be mutually exclusive in every cycle.
REQ-029 A byte arriving in the cycle the FSM returns to IDLE SHALL be processed under IDLE rules.

Reset
REQ-030 Asserting iRst SHALL immediately force: FSM=IDLE, timer=0, holding registers=0, oAddr=0, oWrData=0, oWrEn=0, oRdEn=0, oFrameErr=0, oErrCnt=0, oBusy=0.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame with no strobe and no error count change.

Structure
REQ-032 A shared uart_pkg SHALL hold SOF_BYTE, CMD_WR, CMD_RD and the FSM state encoding, for reuse by the TX-side response framer.
REQ-033 One sub-module, uart_byte_timer (counter, clear, enable, terminal-count output), is natural; all other logic SHALL live in uart_frame_parser.

Verification
REQ-034 Bytes A5 01 10 3C 2D -> 1 cycle after the last iValid: oWrEn=1 for 1 cycle, oAddr=0x10, oWrData=0x3C, oErrCnt=0.
REQ-035 Bytes A5 02 20 00 22 -> oRdEn=1 for 1 cycle, oAddr=0x20, oWrEn never asserted.
REQ-036 Bytes A5 01 10 3C 2C -> oFrameErr=1 for 1 cycle, oErrCnt=1, oAddr/oWrData unchanged from the prior frame.
REQ-037 Bytes 00 FF A5 07 -> the first two bytes are ignored, then oFrameErr pulses after 07, oErrCnt=1, FSM back in IDLE.
REQ-038 TIMEOUT_CYC=16; bytes A5 01, then idle -> oFrameErr exactly 16 cycles after the 01 strobe; a byte arriving on the terminal cycle instead suppresses the error.
REQ-039 iRst pulsed after A5 01 10, then A5 01 10 3C 2D -> no strobe from the partial frame, then a normal write completes and oErrCnt=0; 300 bad frames -> oErrCnt=0xFF.
